// File: rtl/uart_rx_pkg.sv
// Shared state type and parameter defaults for the UART receive controller.
package uart_rx_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 10;
  localparam int DEFAULT_DATA_BITS    = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter that wraps to 1 after reaching rollover_val.
// The count is held at zero while clear is asserted.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_next;

  assign rollover_flag = (count_out == rollover_val);

  // Clear dominates; otherwise step, restarting at 1 once the rollover value was reached
  always_comb begin
    count_next = count_out;
    if (clear) begin
      count_next = '0;
    end else if (count_enable) begin
      if (rollover_flag) begin
        count_next = NUM_CNT_BITS'(1);
      end else begin
        count_next = count_out + NUM_CNT_BITS'(1);
      end
    end
  end

  // Count register with active-low asynchronous reset
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else begin
      count_out <= count_next;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: times start/data/stop bits from an upstream start
// detection pulse, assembles the word LSB-first and flags bad stop bits.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_bit_detected,
  input  logic                 serial_in,
  input  logic                 error_clear,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 busy,
  output logic                 shift_strobe
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2);
  // One cycle ahead of the sample point, so the strobe register lines up with it
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BITS_MAX = BIT_W'(DATA_BITS);

  rx_state_t            state;
  rx_state_t            next_state;
  logic [CNT_W-1:0]     clk_cnt;
  logic                 bit_end;
  logic                 cnt_n_rst;
  logic                 sample;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;
  logic                 accept;
  logic                 shift_en;
  logic                 load_data;
  logic                 set_error;
  logic                 strobe_next;

  assign cnt_n_rst = ~rst;
  assign sample    = (state != IDLE) && (clk_cnt == CNT_MID);
  assign busy      = (state != IDLE);

  flex_counter #(
    .NUM_CNT_BITS(CNT_W)
  ) u_bit_timer (
    .clk          (clk),
    .n_rst        (cnt_n_rst),
    .clear        (state == IDLE),
    .count_enable (state != IDLE),
    .rollover_val (CNT_MAX),
    .count_out    (clk_cnt),
    .rollover_flag(bit_end)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and the per-cycle control strobes for the datapath
  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    shift_en    = 1'b0;
    load_data   = 1'b0;
    set_error   = 1'b0;
    strobe_next = (state == DATA) && (clk_cnt == CNT_PRE);
    case (state)
      IDLE: begin
        if (start_bit_detected) begin
          next_state = START;
          accept     = 1'b1;
        end
      end
      START: begin
        if (sample && serial_in) begin
          next_state = IDLE;
        end else if (bit_end) begin
          next_state = DATA;
        end
      end
      DATA: begin
        shift_en = sample;
        if (bit_end && (bit_cnt == BITS_MAX)) begin
          next_state = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          next_state = IDLE;
          load_data  = serial_in;
          set_error  = ~serial_in;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Right shift with the newest line sample entering at the MSB
  always_comb begin
    shift_next                = shift_reg >> 1;
    shift_next[DATA_BITS-1]   = serial_in;
  end

  // Bit counter, shift register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt       <= '0;
      shift_reg     <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      shift_strobe  <= 1'b0;
    end else begin
      if (accept) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        shift_reg <= shift_next;
        bit_cnt   <= bit_cnt + BIT_W'(1);
      end
      data_valid   <= load_data;
      shift_strobe <= strobe_next;
      if (load_data) begin
        data_out <= shift_reg;
      end
      if (set_error) begin
        framing_error <= 1'b1;
      end else if (error_clear || accept) begin
        framing_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: frame-level timing model with randomized frames,
// false starts, framing errors, back-to-back frames and a mid-frame reset.
module tb_uart_rx_ctrl;

  localparam int CPB       = 10;
  localparam int DB        = 8;
  localparam int MID       = CPB / 2;
  // Offset (edges after acceptance) where a full frame returns to idle
  localparam int FRAME_END = CPB * (DB + 1) + MID + 1;
  // Offset where a false start returns to idle
  localparam int FALSE_END = MID + 1;

  logic          clk                = 1'b0;
  logic          rst                = 1'b0;
  logic          start_bit_detected = 1'b0;
  logic          serial_in          = 1'b1;
  logic          error_clear        = 1'b0;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          framing_error;
  logic          busy;
  logic          shift_strobe;

  int checks = 0;
  int errors = 0;

  logic          e_busy   = 1'b0;
  logic          e_strobe = 1'b0;
  logic          e_dv     = 1'b0;
  logic          e_fe     = 1'b0;
  logic [DB-1:0] e_data   = '0;
  bit            noise_en = 1'b0;

  uart_rx_ctrl #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start_bit_detected(start_bit_detected),
    .serial_in         (serial_in),
    .error_clear       (error_clear),
    .data_out          (data_out),
    .data_valid        (data_valid),
    .framing_error     (framing_error),
    .busy              (busy),
    .shift_strobe      (shift_strobe)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  // Every cycle, compare all outputs with the model on the falling edge
  always @(negedge clk) begin
    if (rst || checks > 0 || $time > 20) begin
      checkOutput("busy",          32'(busy),          32'(e_busy));
      checkOutput("shift_strobe",  32'(shift_strobe),  32'(e_strobe));
      checkOutput("data_valid",    32'(data_valid),    32'(e_dv));
      checkOutput("framing_error", 32'(framing_error), 32'(e_fe));
      checkOutput("data_out",      32'(data_out),      32'(e_data));
    end
  end

  // Advance one clock; pulses last one cycle and a clear seen at the edge drops the error flag
  task automatic tick();
    logic clr;
    clr = error_clear;
    @(posedge clk);
    #1;
    start_bit_detected = 1'b0;
    error_clear        = 1'b0;
    e_strobe           = 1'b0;
    e_dv               = 1'b0;
    if (clr) e_fe = 1'b0;
    if (noise_en && $urandom_range(0, 7) == 0) error_clear = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      e_busy    = 1'b0;
      serial_in = 1'b1;
    end
  endtask

  // Drive one frame starting from the current idle cycle; rise_at>0 makes it a false start,
  // abort_at>=0 asserts reset during that frame cycle. Returns observed strobe count,
  // first data_valid offset and first idle offset (0 = not seen).
  task automatic applyStimulus(input logic [DB-1:0] word, input logic stop_bit,
                               input int rise_at, input int abort_at,
                               output int n_strobe, output int dv_at, output int idle_at);
    int last;
    last     = (rise_at > 0) ? FALSE_END : FRAME_END;
    n_strobe = 0;
    dv_at    = 0;
    idle_at  = 0;
    start_bit_detected = 1'b1;
    serial_in          = 1'b0;
    for (int t = 0; t <= last; t++) begin
      tick();
      e_busy = (t < last);
      if (t == 0) e_fe = 1'b0;
      if (rise_at == 0) begin
        for (int k = 0; k < DB; k++) begin
          if (t == CPB + MID + CPB * k) e_strobe = 1'b1;
        end
        if (t == last) begin
          if (stop_bit) begin
            e_dv   = 1'b1;
            e_data = word;
          end else begin
            e_fe = 1'b1;
          end
        end
      end
      if (t == abort_at) begin
        rst      = 1'b1;
        e_busy   = 1'b0;
        e_strobe = 1'b0;
        e_dv     = 1'b0;
        e_fe     = 1'b0;
        e_data   = '0;
        return;
      end
      if (shift_strobe) n_strobe++;
      if (data_valid && dv_at == 0) dv_at = t;
      if (!busy && idle_at == 0) idle_at = t;
      if (rise_at > 0)              serial_in = (t >= rise_at);
      else if (t <= CPB)            serial_in = 1'b0;
      else if (t <= CPB * (DB + 1)) serial_in = word[(t - CPB - 1) / CPB];
      else if (t < last)            serial_in = stop_bit;
      else                          serial_in = 1'b1;
      if (noise_en && t < last && $urandom_range(0, 5) == 0) start_bit_detected = 1'b1;
    end
  endtask

  // Runaway guard
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized frames
  initial begin
    int ns;
    int dv;
    int idl;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy",  32'(busy),          32'd0);
    checkOutput("reset_fe",    32'(framing_error), 32'd0);
    checkOutput("reset_data",  32'(data_out),      32'd0);
    rst = 1'b0;
    idleCycles(3);

    $display("[TB] good frame 0xA5");
    applyStimulus(8'hA5, 1'b1, 0, -1, ns, dv, idl);
    checkOutput("a5_strobes", 32'(ns),       32'd8);
    checkOutput("a5_dv_at",   32'(dv),       32'd96);
    checkOutput("a5_idle_at", 32'(idl),      32'd96);
    checkOutput("a5_data",    32'(data_out), 32'hA5);
    idleCycles(2);

    $display("[TB] false start");
    applyStimulus(8'h00, 1'b1, 3, -1, ns, dv, idl);
    checkOutput("fs_strobes", 32'(ns),  32'd0);
    checkOutput("fs_dv",      32'(dv),  32'd0);
    checkOutput("fs_idle_at", 32'(idl), 32'd6);
    idleCycles(2);

    $display("[TB] framing error frame 0x3C");
    applyStimulus(8'h3C, 1'b0, 0, -1, ns, dv, idl);
    checkOutput("fe_set",  32'(framing_error), 32'd1);
    checkOutput("fe_dv",   32'(dv),            32'd0);
    checkOutput("fe_data", 32'(data_out),      32'hA5);
    idleCycles(2);
    error_clear = 1'b1;
    idleCycles(1);
    checkOutput("fe_cleared", 32'(framing_error), 32'd0);
    idleCycles(1);

    $display("[TB] back-to-back frames");
    applyStimulus(8'h01, 1'b1, 0, -1, ns, dv, idl);
    checkOutput("b2b1_data", 32'(data_out), 32'h01);
    applyStimulus(8'hFF, 1'b1, 0, -1, ns, dv, idl);
    checkOutput("b2b2_dv_at", 32'(dv),       32'd96);
    checkOutput("b2b2_data",  32'(data_out), 32'hFF);
    idleCycles(1);
    applyStimulus(8'h77, 1'b1, 0, -1, ns, dv, idl);
    checkOutput("b2b3_data", 32'(data_out), 32'h77);
    idleCycles(2);

    $display("[TB] reset mid-frame");
    applyStimulus(8'hC3, 1'b1, 0, 40, ns, dv, idl);
    idleCycles(2);
    rst = 1'b0;
    checkOutput("abort_data", 32'(data_out), 32'd0);
    idleCycles(3);
    applyStimulus(8'h5A, 1'b1, 0, -1, ns, dv, idl);
    checkOutput("post_rst_dv_at", 32'(dv),       32'd96);
    checkOutput("post_rst_data",  32'(data_out), 32'h5A);
    idleCycles(2);

    $display("[TB] randomized frames with spurious pulses");
    noise_en = 1'b1;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 7) == 0) begin
        applyStimulus(DB'($urandom), 1'b1, $urandom_range(1, MID), -1, ns, dv, idl);
      end else begin
        applyStimulus(DB'($urandom), ($urandom_range(0, 3) != 0), 0, -1, ns, dv, idl);
      end
      idleCycles($urandom_range(0, 3));
    end
    noise_en = 1'b0;
    idleCycles(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
